// File: rtl/fixed_point_divider_pipe.sv
// Sequential radix-2 restoring divider for signed/unsigned Q(WIDTH-FRAC).FRAC operands.
// Produces one quotient bit per cycle, then saturates/negates in a final cycle before presenting the result.
module fixed_point_divider_pipe #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  // Handshake: an operand pair transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. in_ready is high
  // only in IDLE, out_valid only in DONE, so accept and deliver never share a cycle.
  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]     num_q;
  logic [WIDTH:0]   rem_q;
  logic [N-1:0]     acc_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] dz_quotient;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [N-1:0]     limit;
  logic [WIDTH-1:0] sat_value;
  logic             acc_over;
  logic [WIDTH-1:0] q_trunc;
  logic [WIDTH-1:0] q_final;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand conditioning; the most-negative value maps to magnitude 2^(WIDTH-1).
  always_comb begin
    dividend_neg = (SIGNED != 0) && dividend[WIDTH-1];
    divisor_neg  = (SIGNED != 0) && divisor[WIDTH-1];
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
    dz_quotient  = '1;
    if (SIGNED != 0) begin
      dz_quotient = dividend[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // One restoring step: the partial remainder stays below the divisor magnitude,
  // so its shifted form always fits in WIDTH+1 bits.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], num_q[N-1]};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    rem_sub   = rem_shift - {1'b0, dvs_q};
  end

  // Range limit depends on the result sign: negative results may reach -2^(WIDTH-1).
  always_comb begin
    limit     = '0;
    sat_value = '1;
    if (SIGNED != 0) begin
      if (neg_q) begin
        limit[WIDTH-1] = 1'b1;
        sat_value      = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        limit[WIDTH-2:0] = '1;
        sat_value        = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      limit[WIDTH-1:0] = '1;
    end
    acc_over = (acc_q > limit);
    q_trunc  = acc_q[WIDTH-1:0];
    q_final  = neg_q ? (~q_trunc + 1'b1) : q_trunc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(N - 1)) begin
          state_nxt = FINAL;
        end
      end
      FINAL: state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= dz_quotient;
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
            end else begin
              num_q <= N'(dividend_mag) << FRAC;
              rem_q <= '0;
              acc_q <= '0;
              dvs_q <= divisor_mag;
              neg_q <= dividend_neg ^ divisor_neg;
              cnt_q <= '0;
            end
          end
        end
        CALC: begin
          num_q <= num_q << 1;
          rem_q <= rem_ge ? rem_sub : rem_shift;
          acc_q <= {acc_q[N-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        FINAL: begin
          quotient    <= acc_over ? sat_value : q_final;
          overflow    <= acc_over;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_pipe.sv
// Directed bench for fixed_point_divider_pipe: default signed Q8.8 instance plus an unsigned Q4.4 instance.
// Expected results are queued when operands are driven and popped when out_valid appears.
module tb_fixed_point_divider_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, overflow, div_by_zero;
  logic [15:0] dividend, divisor, quotient;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_overflow, u_div_by_zero;
  logic [7:0]  u_dividend, u_divisor, u_quotient;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [1:0]  exp_f[$];
  int          exp_lat[$];

  always #5 clk = ~clk;

  fixed_point_divider_pipe u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  fixed_point_divider_pipe #(.WIDTH(8), .FRAC(4), .SIGNED(0)) u_uns (
    .clk(clk), .reset(reset),
    .in_valid(u_in_valid), .in_ready(u_in_ready),
    .dividend(u_dividend), .divisor(u_divisor),
    .out_valid(u_out_valid), .out_ready(u_out_ready),
    .quotient(u_quotient), .overflow(u_overflow), .div_by_zero(u_div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair, waits for the accepting edge, then scrambles the inputs.
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic ov, input logic dz, input int lat);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    exp_q.push_back(q);
    exp_f.push_back({ov, dz});
    exp_lat.push_back(lat);
    step();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  // Waits for out_valid (bounded), compares against the queue, optionally stalls, then hands off.
  task automatic collect(input string tag, input int spent, input int hold);
    int          cyc;
    int          lat;
    logic [15:0] q;
    logic [1:0]  f;
    cyc = spent;
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
    end
    q   = exp_q.pop_front();
    f   = exp_f.pop_front();
    lat = exp_lat.pop_front();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_quotient"}, 32'(quotient), 32'(q));
    check({tag, "_overflow"}, 32'(overflow), 32'(f[1]));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(f[0]));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_quotient"}, 32'(quotient), 32'(q));
      check({tag, "_hold_flags"}, 32'({overflow, div_by_zero}), 32'(f));
      check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_quotient_kept"}, 32'(quotient), 32'(q));
  endtask

  task automatic u_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] q, input logic ov, input logic dz, input int lat);
    int cyc;
    check({tag, "_in_ready"}, 32'(u_in_ready), 32'd1);
    u_dividend = a;
    u_divisor  = b;
    u_in_valid = 1'b1;
    exp_q.push_back(16'(q));
    exp_f.push_back({ov, dz});
    exp_lat.push_back(lat);
    step();
    u_in_valid = 1'b0;
    u_dividend = 8'($urandom);
    cyc = 0;
    while (!u_out_valid && cyc < 200) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat.pop_front()));
    check({tag, "_quotient"}, 32'(u_quotient), 32'(exp_q.pop_front()));
    check({tag, "_flags"}, 32'({u_overflow, u_div_by_zero}), 32'(exp_f.pop_front()));
    u_out_ready = 1'b1;
    step();
    u_out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(u_out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    u_in_valid  = 1'b0;
    u_out_ready = 1'b0;
    u_dividend  = '0;
    u_divisor   = '0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_flags", 32'({overflow, div_by_zero}), 32'd0);
    reset = 1'b0;
    step();

    // Basic and signed cases (3/2, -3/2, 1/3, -1/3), issued back-to-back.
    drive(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);
    collect("div_3_2", 0, 0);
    drive(16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25);
    collect("div_m3_2", 0, 0);
    drive(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
    collect("div_1_3", 0, 0);
    drive(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25);
    collect("div_m1_3", 0, 0);

    // Saturation boundaries.
    drive(16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 25);
    collect("sat_pos", 0, 0);
    drive(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);
    collect("sat_minneg", 0, 0);
    drive(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25);
    collect("min_exact", 0, 0);

    // Divide by zero: result appears right after the accepting edge.
    drive(16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0);
    collect("dz_pos", 0, 0);
    drive(16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 0);
    collect("dz_neg", 0, 0);

    // Consumer stall for 10 cycles.
    drive(16'h0500, 16'h0400, 16'h0140, 1'b0, 1'b0, 25);
    collect("stall", 0, 10);

    // in_valid pulsed mid-calculation must not disturb the running operation.
    drive(16'h0700, 16'h0200, 16'h0380, 1'b0, 1'b0, 25);
    repeat (5) step();
    check("busy_in_ready", 32'(in_ready), 32'd0);
    dividend = 16'h0100;
    divisor  = 16'h0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    collect("busy_pulse", 6, 0);

    // Reset during iteration 10 aborts the operation.
    dividend = 16'h0300;
    divisor  = 16'h0200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #2;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_flags", 32'({overflow, div_by_zero}), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    check("abort_idle", 32'(in_ready), 32'd1);

    // Unsigned Q4.4 instance: 15.0/2.0, saturation, divide by zero.
    u_op("u_div", 8'hF0, 8'h20, 8'h78, 1'b0, 1'b0, 13);
    u_op("u_sat", 8'hF0, 8'h01, 8'hFF, 1'b1, 1'b0, 13);
    u_op("u_dz", 8'h40, 8'h00, 8'hFF, 1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
